// File: rtl/fc_stream_tx.sv
// rtl/fc_stream_tx.sv - fast-command serial transmitter: command queue, 8-bit MSB-first frames, IDLE fill.
// Optional orbit-sync frame insertion is built when FC_TX_ORBIT_SYNC_EN is defined.
module fc_stream_tx #(
    parameter logic [7:0] IDLE_CODE  = 8'hAC,
    parameter int         FIFO_DEPTH = 4,
    parameter int         ORBIT_LEN  = 3564,
    parameter logic [7:0] ORBIT_CODE = 8'h2D
) (
    input  logic                        clk320,
    input  logic                        reset_in,
    input  logic [7:0]                  cmd_data,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        FC_invert,
    input  logic                        orbit_en,
    output logic                        FC_out,
    output logic                        frame_strobe,
    output logic                        cmd_sent,
    output logic                        orbit_strobe,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_fc_out;
    logic          r_frame_strobe;
    logic          r_cmd_sent;

    logic w_boundary;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_orbit_load;

    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_full     = (r_level == LW'(FIFO_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_push     = cmd_valid & ~w_full;
    // Registered level only: a word written on the boundary cycle waits for the next frame.
    assign w_pop      = w_boundary & ~w_empty & ~w_orbit_load;

`ifdef FC_TX_ORBIT_SYNC_EN
    localparam int OW = (ORBIT_LEN > 1) ? $clog2(ORBIT_LEN) : 1;

    logic [OW-1:0] r_orbit_cnt;
    logic          r_orbit_strobe;

    assign w_orbit_load = w_boundary & orbit_en & (r_orbit_cnt == '0);

    // Counter free-runs regardless of orbit_en so the orbit phase never drifts.
    always_ff @(posedge clk320 or posedge reset_in) begin
        if (reset_in) begin
            r_orbit_cnt    <= '0;
            r_orbit_strobe <= 1'b0;
        end else begin
            r_orbit_strobe <= w_orbit_load;
            if (w_boundary) begin
                if (r_orbit_cnt == OW'(ORBIT_LEN - 1)) begin
                    r_orbit_cnt <= '0;
                end else begin
                    r_orbit_cnt <= r_orbit_cnt + OW'(1);
                end
            end
        end
    end

    assign orbit_strobe = r_orbit_strobe;
`else
    logic w_unused_orbit;

    assign w_unused_orbit = orbit_en ^ (^ORBIT_CODE) ^ ORBIT_LEN[0];
    assign w_orbit_load   = 1'b0;
    assign orbit_strobe   = 1'b0;
`endif

    always_ff @(posedge clk320) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk320 or posedge reset_in) begin
        if (reset_in) begin
            r_bit_cnt      <= 3'd0;
            r_shreg        <= IDLE_CODE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_fc_out       <= 1'b0;
            r_frame_strobe <= 1'b0;
            r_cmd_sent     <= 1'b0;
        end else begin
            r_fc_out       <= r_shreg[7] ^ FC_invert;
            r_frame_strobe <= (r_bit_cnt == 3'd0);
            r_cmd_sent     <= w_pop;

            if (w_boundary) begin
                r_bit_cnt <= 3'd0;
                if (w_orbit_load) begin
                    r_shreg <= ORBIT_CODE;
                end else if (w_pop) begin
                    r_shreg <= r_mem[r_rd_ptr];
                end else begin
                    r_shreg <= IDLE_CODE;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shreg   <= {r_shreg[6:0], 1'b0};
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign cmd_ready    = ~w_full;
    assign FC_out       = r_fc_out;
    assign frame_strobe = r_frame_strobe;
    assign cmd_sent     = r_cmd_sent;
    assign fifo_level   = r_level;

endmodule

// File: tb/tb_fc_stream_tx.sv
// tb/tb_fc_stream_tx.sv - randomized scoreboard bench for fc_stream_tx.
module tb_fc_stream_tx;
    localparam int         DEPTH = 4;
    localparam logic [7:0] IDLE  = 8'hAC;
    localparam logic [7:0] OCODE = 8'h2D;
    localparam int         OLEN  = 4;

    logic       clk320 = 1'b0;
    logic       rst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       FC_invert;
    logic       orbit_en;
    logic       FC_out;
    logic       frame_strobe;
    logic       cmd_sent;
    logic       orbit_strobe;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_pass = 0;
    int cyc;
    int peak_level = 0;
    int frames_checked = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_frames[$];
    int         exp_sent[$];
    int         exp_orbit[$];

    fc_stream_tx #(
        .IDLE_CODE (IDLE),
        .FIFO_DEPTH(DEPTH),
        .ORBIT_LEN (OLEN),
        .ORBIT_CODE(OCODE)
    ) dut (
        .clk320      (clk320),
        .reset_in    (rst),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .FC_invert   (FC_invert),
        .orbit_en    (orbit_en),
        .FC_out      (FC_out),
        .frame_strobe(frame_strobe),
        .cmd_sent    (cmd_sent),
        .orbit_strobe(orbit_strobe),
        .fifo_level  (fifo_level)
    );

    always #5 clk320 = ~clk320;

    always @(posedge clk320 or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic void chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    // Frame k+1 is chosen at the end of cycle 8k+7; orbit frames fall on every OLEN-th choice.
    function automatic bit orbit_due(input int c);
`ifdef FC_TX_ORBIT_SYNC_EN
        return orbit_en && (((c / 8) % OLEN) == 0);
`else
        return (c < 0);
`endif
    endfunction

    task automatic run_cycles(input int n, input int p_valid, input int p_inv);
        int         c;
        int         sz0;
        logic       v;
        logic       rdy;
        logic [7:0] d;
        logic [7:0] f;
        for (int i = 0; i < n; i++) begin
            c   = cyc;
            sz0 = mq.size();
            rdy = (sz0 < DEPTH);
            v   = (int'($urandom_range(99)) < p_valid);
            d   = 8'($urandom);
            cmd_valid = v;
            cmd_data  = d;
            if (int'($urandom_range(99)) < p_inv) FC_invert = ~FC_invert;
            if (c % 8 == 7) begin
                if (orbit_due(c)) begin
                    exp_frames.push_back(OCODE);
                    exp_orbit.push_back(c + 1);
                end else if (mq.size() > 0) begin
                    f = mq.pop_front();
                    exp_frames.push_back(f);
                    exp_sent.push_back(c + 1);
                end else begin
                    exp_frames.push_back(IDLE);
                end
            end
            if (v && rdy) mq.push_back(d);
            @(negedge clk320);
            chk("cmd_ready", int'(cmd_ready), int'(rdy));
            chk("fifo_level", int'(fifo_level), sz0);
            if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
            @(posedge clk320);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin : monitor
        int         nbits;
        logic [7:0] acc;
        logic       inv_prev;
        logic       b;
        nbits    = 0;
        acc      = '0;
        inv_prev = 1'b0;
        forever begin
            @(negedge clk320);
            if (rst) begin
                nbits    = 0;
                inv_prev = FC_invert;
                continue;
            end
            b        = FC_out ^ inv_prev;
            inv_prev = FC_invert;
            chk("frame_strobe", int'(frame_strobe), int'(cyc % 8 == 1));
            if (frame_strobe) begin
                acc   = {7'd0, b};
                nbits = 1;
            end else if (nbits > 0) begin
                acc   = {acc[6:0], b};
                nbits = nbits + 1;
            end
            if (nbits == 8) begin
                nbits = 0;
                if (exp_frames.size() == 0) chk("frame_extra", int'(acc), -1);
                else begin
                    chk("frame", int'(acc), int'(exp_frames.pop_front()));
                    frames_checked++;
                end
            end
            if (cmd_sent) begin
                if (exp_sent.size() == 0) chk("cmd_sent_extra", cyc, -1);
                else chk("cmd_sent_cycle", cyc, exp_sent.pop_front());
            end
            if (orbit_strobe) begin
                if (exp_orbit.size() == 0) chk("orbit_strobe_extra", cyc, -1);
                else chk("orbit_strobe_cycle", cyc, exp_orbit.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        FC_invert = 1'b0;
        orbit_en  = 1'b1;
        exp_frames.push_back(IDLE);
        repeat (3) @(posedge clk320);
        #1;
        chk("rst_FC_out", int'(FC_out), 0);
        chk("rst_frame_strobe", int'(frame_strobe), 0);
        chk("rst_cmd_sent", int'(cmd_sent), 0);
        chk("rst_orbit_strobe", int'(orbit_strobe), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        rst = 1'b0;

        run_cycles(40, 0, 0);
        FC_invert = 1'b1;
        run_cycles(24, 0, 0);
        FC_invert = 1'b0;
        run_cycles(300, 15, 5);
        run_cycles(100, 100, 0);
        run_cycles(60, 0, 0);
        chk("peak_level", peak_level, DEPTH);
        chk("sent_drained", exp_sent.size(), 0);

        run_cycles(3, 100, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_FC_out", int'(FC_out), 0);
        chk("midrst_fifo_level", int'(fifo_level), 0);
        chk("midrst_frame_strobe", int'(frame_strobe), 0);
        chk("midrst_cmd_sent", int'(cmd_sent), 0);
        chk("midrst_cmd_ready", int'(cmd_ready), 1);
        mq.delete();
        exp_frames.delete();
        exp_sent.delete();
        exp_orbit.delete();
        exp_frames.push_back(IDLE);
        repeat (2) @(posedge clk320);
        #1;
        rst = 1'b0;

        run_cycles(120, 30, 5);
        run_cycles(60, 0, 0);
        chk("sent_drained2", exp_sent.size(), 0);
        chk("orbit_drained", exp_orbit.size(), 0);
        chk("frames_pending", int'(exp_frames.size() <= 2), 1);
        chk("frames_seen", int'(frames_checked >= 60), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
